// File: rtl/fifo_sym_pack.sv
// fifo_sym_pack: repacks the 3-bit symbol stream read from the bit buffer into
// LSB-first bytes and queues them in a small valid/ready output queue. The
// upstream FIFO controller cannot be stalled, so a byte that finds the queue
// full is dropped and recorded in the sticky lost flag.
module fifo_sym_pack #(
  parameter int QDEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       out_en,
  input  logic [2:0] sym,
  input  logic       flush,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [2:0] level,
  output logic       lost
);

  // Pointer width is tied to the fixed 4-entry queue.
  localparam int PW = 2;

  // Accumulator state: acc holds unconsumed bits, cnt counts them (0..7).
  logic [9:0] acc_reg, acc_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       flush_pend_reg;

  // Output queue state.
  logic [7:0]    mem [QDEPTH];
  logic [PW-1:0] wptr_reg, rptr_reg;
  logic [2:0]    level_reg, level_next;
  logic          lost_reg;

  // Byte-formation results for the current cycle.
  logic       push;
  logic [7:0] push_data;
  logic       flush_act;
  logic [9:0] merged;
  logic [3:0] sum;
  logic [7:0] keep_mask;

  // Queue handshake terms.
  logic pop;
  logic full;
  logic do_write;
  logic lost_set;

  // Insert the new symbol above the held bits, or zero-pad on a pending flush.
  always_comb begin
    acc_next  = acc_reg;
    cnt_next  = cnt_reg;
    push      = 1'b0;
    push_data = 8'h00;
    flush_act = 1'b0;
    merged    = acc_reg;
    sum       = cnt_reg + 4'd3;
    keep_mask = 8'hFF >> (4'd8 - cnt_reg);
    if (out_en) begin
      // Clear the target slot first so stale bits can never leak in.
      merged = (acc_reg & ~(10'd7 << cnt_reg)) | ({7'd0, sym} << cnt_reg);
      if (sum >= 4'd8) begin
        push      = 1'b1;
        push_data = merged[7:0];
        acc_next  = merged >> 8;
        cnt_next  = sum - 4'd8;
      end else begin
        acc_next = merged;
        cnt_next = sum;
      end
    end else if (flush_pend_reg) begin
      // Flush only acts on an idle cycle so in-flight symbols are packed first.
      flush_act = 1'b1;
      if (cnt_reg != 4'd0) begin
        push      = 1'b1;
        push_data = acc_reg[7:0] & keep_mask;
      end
      acc_next = 10'd0;
      cnt_next = 4'd0;
    end
  end

  // Queue control: a pop frees the head slot, so push+pop succeeds even when full.
  always_comb begin
    pop      = byte_valid && byte_ready;
    full     = (level_reg == 3'd4);
    do_write = push && (!full || pop);
    lost_set = push && full && !pop;
    level_next = level_reg;
    if (do_write && !pop) begin
      level_next = level_reg + 3'd1;
    end else if (!do_write && pop) begin
      level_next = level_reg - 3'd1;
    end
  end

  // Accumulator, bit count and deferred-flush flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_reg        <= 10'd0;
      cnt_reg        <= 4'd0;
      flush_pend_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      if (flush) begin
        flush_pend_reg <= 1'b1;
      end else if (flush_act) begin
        flush_pend_reg <= 1'b0;
      end
    end
  end

  // Queue storage; entries reset so an empty queue presents 0x00.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_write) begin
      mem[wptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= 3'd0;
      lost_reg  <= 1'b0;
    end else begin
      if (do_write) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      level_reg <= level_next;
      if (lost_set) begin
        lost_reg <= 1'b1;
      end
    end
  end

  assign byte_data  = mem[rptr_reg];
  assign byte_valid = (level_reg != 3'd0);
  assign level      = level_reg;
  assign lost       = lost_reg;

endmodule

// File: tb/tb_fifo_sym_pack.sv
// Testbench for fifo_sym_pack: directed cases plus randomized traffic checked
// by a scoreboard fed from a bit-queue reference model.
module tb_fifo_sym_pack;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       out_en = 1'b0;
  logic [2:0] sym = 3'd0;
  logic       flush = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [2:0] level;
  logic       lost;

  fifo_sym_pack #(.QDEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .out_en(out_en), .sym(sym), .flush(flush),
    .byte_ready(byte_ready), .byte_data(byte_data), .byte_valid(byte_valid),
    .level(level), .lost(lost)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;

  // Reference model: pending stream bits, expected queued bytes, occupancy.
  bit         bitq[$];
  logic [7:0] exp_q[$];
  int         m_level = 0;
  bit         m_lost = 0;
  bit         m_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the effect of the edge.
  task automatic cycle(input bit oe, input logic [2:0] s, input bit fl, input bit rdy);
    bit pop;
    bit have;
    logic [7:0] b;
    out_en = oe; sym = s; flush = fl; byte_ready = rdy;
    pop  = (m_level > 0) && rdy;
    have = 0;
    b    = 8'h00;
    if (oe) begin
      for (int i = 0; i < 3; i++) bitq.push_back(s[i]);
      if (bitq.size() >= 8) begin
        for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
        have = 1;
      end
    end else if (m_pend) begin
      if (bitq.size() > 0) begin
        while (bitq.size() < 8) bitq.push_back(1'b0);
        for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
        have = 1;
      end
      bitq.delete();
    end
    m_pend = fl ? 1'b1 : (oe ? m_pend : 1'b0);
    @(posedge Clk);
    #1;
    if (pop) m_level--;
    if (have) begin
      if (m_level == 4) m_lost = 1;
      else begin
        exp_q.push_back(b);
        m_level++;
      end
    end
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic mid_reset();
    out_en = 0; flush = 0; byte_ready = 0;
    #1 Rst = 1'b1;
    #1;
    chk("rst_valid", byte_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_lost", lost, 0);
    bitq.delete(); exp_q.delete();
    m_level = 0; m_lost = 0; m_pend = 0;
    #1 Rst = 1'b0;
  endtask

  // Monitor: compares head byte, occupancy and flags; retires popped bytes.
  always @(negedge Clk) begin
    if (started && !Rst) begin
      chk("level", level, m_level);
      chk("lost", lost, m_lost);
      chk("valid", byte_valid, (m_level != 0));
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL head: got 0x%0h expected no byte at %0t", byte_data, $time);
        end else begin
          chk("head", byte_data, exp_q[0]);
          if (byte_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("init_valid", byte_valid, 0);
    chk("init_data", byte_data, 8'h00);
    chk("init_level", level, 0);
    chk("init_lost", lost, 0);
    started = 1;

    // Pack order: 5,3,6 -> 0x9D
    cycle(1, 3'd5, 0, 1); cycle(1, 3'd3, 0, 1); cycle(1, 3'd6, 0, 1);
    chk("pack_9d", byte_data, 8'h9D);
    // Flush the single leftover bit -> 0x01, then an empty flush
    cycle(0, 0, 1, 1); cycle(0, 0, 0, 1);
    chk("flush_01", byte_data, 8'h01);
    cycle(0, 0, 1, 1); cycle(0, 0, 0, 1);
    chk("flush_empty", byte_valid, 0);

    // 24-bit alignment
    for (int i = 0; i < 8; i++) cycle(1, 3'(i), 0, 0);
    chk("align_level", level, 3);
    chk("align_88", byte_data, 8'h88);
    repeat (4) cycle(0, 0, 0, 1);

    // Overflow: 14 x 7 with consumer stalled
    for (int i = 0; i < 14; i++) cycle(1, 3'd7, 0, 0);
    chk("ovf_level", level, 4);
    chk("ovf_lost", lost, 1);
    repeat (4) cycle(0, 0, 0, 1);
    chk("ovf_drained", level, 0);
    chk("ovf_lost_sticky", lost, 1);
    cycle(0, 0, 1, 1); cycle(0, 0, 0, 1); repeat (2) cycle(0, 0, 0, 1);

    // Full push+pop
    @(posedge Clk); mid_reset();
    for (int i = 0; i < 13; i++) cycle(1, 3'($urandom_range(0, 7)), 0, 0);
    chk("full_level", level, 4);
    cycle(1, 3'($urandom_range(0, 7)), 0, 1);
    chk("pushpop_level", level, 4);
    chk("pushpop_lost", lost, 0);
    repeat (5) cycle(0, 0, 0, 1);

    // Reset mid-operation with level=3, cnt=5
    cycle(1, 3'd2, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 3'd7, 0, 0);
    chk("pre_rst_level", level, 3);
    mid_reset();
    cycle(1, 3'd5, 0, 0); cycle(1, 3'd3, 0, 0); cycle(1, 3'd6, 0, 0);
    chk("post_rst_9d", byte_data, 8'h9D);
    repeat (2) cycle(0, 0, 0, 1);

    // Randomized traffic with windows of varying consumer behaviour
    for (int w = 0; w < 15; w++) begin
      int rdy_pct;
      rdy_pct = (w % 3 == 0) ? 100 : ((w % 3 == 1) ? 20 : 60);
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)),
              $urandom_range(0, 31) == 0, $urandom_range(0, 99) < rdy_pct);
      end
    end

    // Final flush and drain
    cycle(0, 0, 1, 1);
    repeat (10) cycle(0, 0, 0, 1);
    chk("final_level", level, 0);
    chk("final_scoreboard", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
